// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode: DEPTH-entry circular buffer of {pc, instr}
// with a valid/ready handshake on each side and a single-cycle flush.
module fetch_queue #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic [31:0]                instr_in,
   input  logic [31:0]                pc_in,
   input  logic                       valid_in,
   output logic                       ready_in,
   output logic [31:0]                instr,
   output logic [31:0]                pc_out,
   output logic                       valid_out,
   input  logic                       ready_out,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [63:0]   slot_q [DEPTH];
   logic [PW-1:0] hptr_q, hptr_d;
   logic [PW-1:0] tptr_q, tptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop;
   logic [63:0]   head;

   // Outputs depend only on registered state and reset/flush, never on valid_in/ready_out.
   assign ready_in  = !reset && !flush && (count_q < FULL_CNT);
   assign valid_out = !reset && !flush && (count_q != '0);
   assign push      = valid_in && ready_in;
   assign pop       = valid_out && ready_out;

   assign head   = slot_q[hptr_q];
   assign instr  = valid_out ? head[31:0]  : 32'h0;
   assign pc_out = valid_out ? head[63:32] : 32'h0;
   assign count  = count_q;

   always_comb begin
      hptr_d  = hptr_q;
      tptr_d  = tptr_q;
      count_d = count_q;
      if (push) tptr_d = tptr_q + PW'(1);
      if (pop)  hptr_d = hptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (flush) begin
         hptr_d  = '0;
         tptr_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hptr_q  <= '0;
         tptr_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
      end else begin
         hptr_q  <= hptr_d;
         tptr_q  <= tptr_d;
         count_q <= count_d;
         if (push) slot_q[tptr_q] <= {pc_in, instr_in};
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stimulus enqueues expected {pc, instr} pairs, a negedge
// monitor pops and compares whenever decode takes the head.
module tb_fetch_queue;

   logic        clk;
   logic        reset;
   logic        flush;
   logic [31:0] instr_in;
   logic [31:0] pc_in;
   logic        valid_in;
   logic        ready_in;
   logic [31:0] instr;
   logic [31:0] pc_out;
   logic        valid_out;
   logic        ready_out;
   logic [2:0]  count;

   int vectors    = 0;
   int miscompares = 0;
   logic [63:0] exp_q [$];

   fetch_queue #(.DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .instr_in  (instr_in),
      .pc_in     (pc_in),
      .valid_in  (valid_in),
      .ready_in  (ready_in),
      .instr     (instr),
      .pc_out    (pc_out),
      .valid_out (valid_out),
      .ready_out (ready_out),
      .count     (count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // inputs change 1 time unit after the rising edge
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_push(input logic [31:0] pc, input logic [31:0] ins, input bit accepted);
      valid_in = 1'b1;
      pc_in    = pc;
      instr_in = ins;
      if (accepted) exp_q.push_back({pc, ins});
   endtask

   // Monitor: every handshake on the decode side must match the oldest expected entry.
   always @(negedge clk) begin
      if (valid_out === 1'b1 && ready_out === 1'b1) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL pop_unexpected: got pc %h instr %h expected no entry", pc_out, instr);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            if (pc_out !== e[63:32] || instr !== e[31:0]) begin
               miscompares++;
               $display("FAIL pop_data: got pc %h instr %h expected pc %h instr %h",
                        pc_out, instr, e[63:32], e[31:0]);
            end
         end
      end
   end

   initial begin
      logic [31:0] fill_instr [4];
      fill_instr[0] = 32'hFFF30293;
      fill_instr[1] = 32'hABCDE1B7;
      fill_instr[2] = 32'h005201B3;
      fill_instr[3] = 32'hFF042503;

      reset = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_out = 1'b0;
      pc_in = '0; instr_in = '0;

      // reset / idle
      tick;
      chk("rst_ready_in", 32'(ready_in), 32'd0);
      chk("rst_valid_out", 32'(valid_out), 32'd0);
      tick;
      reset = 1'b0;
      #1;
      chk("idle_count", 32'(count), 32'd0);
      chk("idle_valid_out", 32'(valid_out), 32'd0);
      chk("idle_instr", instr, 32'h0);
      chk("idle_pc", pc_out, 32'h0);
      chk("idle_ready_in", 32'(ready_in), 32'd1);

      // fill to full with decode stalled
      for (int i = 0; i < 4; i++) begin
         drive_push(32'(i * 4), fill_instr[i], 1'b1);
         if (i == 0) begin
            #1;
            chk("no_bypass_valid", 32'(valid_out), 32'd0);
         end
         tick;
      end
      drive_push(32'h10, 32'h12345678, 1'b0);
      #1;
      chk("full_count", 32'(count), 32'd4);
      chk("full_ready_in", 32'(ready_in), 32'd0);
      chk("full_head_pc", pc_out, 32'h0);
      chk("full_head_instr", instr, 32'hFFF30293);
      tick;
      chk("full_hold_count", 32'(count), 32'd4);
      valid_in = 1'b0;
      ready_out = 1'b1;
      tick;
      chk("drain1_count", 32'(count), 32'd3);
      tick; tick; tick;
      #1;
      chk("drained_count", 32'(count), 32'd0);
      chk("drained_valid", 32'(valid_out), 32'd0);

      // streaming push+pop, pointers wrap three times
      for (int i = 0; i < 12; i++) begin
         drive_push(32'h200 + 32'(i * 4), 32'hA000_0000 | 32'(i), 1'b1);
         tick;
         chk("stream_count", 32'(count), 32'd1);
      end
      valid_in = 1'b0;
      tick;
      chk("stream_end_count", 32'(count), 32'd0);

      // simultaneous push and pop at full
      ready_out = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_push(32'h300 + 32'(i * 4), 32'hB000_0000 | 32'(i), 1'b1);
         tick;
      end
      drive_push(32'h400, 32'hDEADBEEF, 1'b0);
      ready_out = 1'b1;
      #1;
      chk("fullpp_ready_in", 32'(ready_in), 32'd0);
      chk("fullpp_valid_out", 32'(valid_out), 32'd1);
      tick;
      valid_in = 1'b0;
      ready_out = 1'b0;
      #1;
      chk("fullpp_count", 32'(count), 32'd3);
      chk("fullpp_ready_after", 32'(ready_in), 32'd1);

      // flush with count = 3 and both handshakes requested
      flush = 1'b1;
      drive_push(32'h500, 32'hC0FFEE00, 1'b0);
      ready_out = 1'b1;
      exp_q.delete();
      #1;
      chk("flush_ready_in", 32'(ready_in), 32'd0);
      chk("flush_valid_out", 32'(valid_out), 32'd0);
      chk("flush_instr", instr, 32'h0);
      tick;
      flush = 1'b0;
      valid_in = 1'b0;
      ready_out = 1'b0;
      #1;
      chk("post_flush_count", 32'(count), 32'd0);
      chk("post_flush_ready", 32'(ready_in), 32'd1);
      drive_push(32'h100, 32'h00000013, 1'b1);
      tick;
      valid_in = 1'b0;
      #1;
      chk("post_flush_valid", 32'(valid_out), 32'd1);
      chk("post_flush_pc", pc_out, 32'h100);
      chk("post_flush_instr", instr, 32'h00000013);
      ready_out = 1'b1;
      tick;
      ready_out = 1'b0;

      // reset during operation with a push pending
      drive_push(32'h600, 32'hE0000001, 1'b1);
      tick;
      drive_push(32'h604, 32'hE0000002, 1'b1);
      tick;
      chk("pre_rst_count", 32'(count), 32'd2);
      drive_push(32'h608, 32'hE0000003, 1'b0);
      reset = 1'b1;
      exp_q.delete();
      #1;
      chk("midrst_ready_in", 32'(ready_in), 32'd0);
      chk("midrst_valid_out", 32'(valid_out), 32'd0);
      tick;
      reset = 1'b0;
      valid_in = 1'b0;
      #1;
      chk("after_rst_count", 32'(count), 32'd0);
      chk("after_rst_valid", 32'(valid_out), 32'd0);
      chk("after_rst_instr", instr, 32'h0);
      chk("after_rst_pc", pc_out, 32'h0);
      ready_out = 1'b1;
      tick;
      tick;
      chk("no_stale_valid", 32'(valid_out), 32'd0);
      chk("no_stale_count", 32'(count), 32'd0);
      ready_out = 1'b0;

      tick;
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction queue between fetch and `decode` in the out-of-order core. It buffers up to DEPTH fetched {pc, instr} pairs and presents the oldest one to `decode` over a valid/ready handshake. It also decouples fetch from rename/dispatch back-pressure. A flush input empties the queue in one cycle on branch mispredict or exception redirect.

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all queued entries this cycle
- instr_in  in  32  instruction word from fetch
- pc_in  in  32  PC of instr_in
- valid_in  in  1  fetch presents an instruction
- ready_in  out  1  queue can accept an instruction this cycle
- instr  out  32  head instruction, wired to decode `instr`
- pc_out  out  32  head PC, wired to decode `pc_in`
- valid_out  out  1  head entry is valid, wired to decode `valid_in`
- ready_out  in  1  decode accepts head, wired from decode `ready_in`
- count  out  $clog2(DEPTH+1)  number of occupied entries

## Operation
- Storage: DEPTH-entry circular buffer of {pc, instr}, with head pointer hptr, tail pointer tptr, and occupancy count.
- Push: valid_in && ready_in. Writes {pc_in, instr_in} to slot tptr and sets tptr ← (tptr+1) mod DEPTH.
- Pop: valid_out && ready_out. Sets hptr ← (hptr+1) mod DEPTH.
- count ← count + push − pop. Simultaneous push and pop leaves count unchanged.
- ready_in = !reset && !flush && (count < DEPTH).
- valid_out = !reset && !flush && (count != 0).
- instr/pc_out = slot[hptr] when valid_out, else 32'h0.
- No bypass: a pushed entry is not visible on instr/pc_out until the next cycle, even when the queue is empty.
- Full (count == DEPTH): ready_in = 0. A pop in this cycle does not re-enable ready_in until the next cycle.
- Empty (count == 0): valid_out = 0. A push makes valid_out = 1 in the next cycle.
- Flush: highest priority after reset. In the flush cycle, push and pop are suppressed because ready_in = valid_out = 0. On the edge, hptr = tptr = count = 0. Storage contents are not cleared, since they are unobservable. The queue accepts pushes again in the next cycle.
- Reset: in the cycle where reset is high, hptr = tptr = count = 0 and all storage slots are cleared to 0.
- Pointer wrap: hptr and tptr wrap from DEPTH−1 to 0 with no skipped or duplicated entries.
- Ordering: entries leave in strict push order; no reordering and no dropping except by flush or reset.

## Timing
- Reset values: ready_in = 0 and valid_out = 0 while reset is high. Afterward, count = 0, instr = pc_out = 0, valid_out = 0, and ready_in = 1 in the first cycle after reset deasserts.
- Latency: push at edge N → entry on outputs and valid_out = 1 from cycle N+1, provided it is at the head.
- Throughput: one push and one pop per cycle sustained at any count in 1..DEPTH−1.
- Stability: while valid_out && !ready_out && !flush, instr/pc_out/valid_out hold their values across edges.
- All outputs are functions of registered state plus reset/flush only. Nothing depends combinationally on valid_in or ready_out.

## Test plan
- Reset/idle: hold reset for 2 cycles, then release → count = 0, valid_out = 0, instr = 0, ready_in = 1 in the first post-reset cycle.
- Fill and drain order: ready_out = 0; push PC 0x00/0x04/0x08/0x0C with instr 0xFFF30293, 0xABCDE1B7, 0x005201B3, 0xFF042503 → count = 4 and ready_in = 0. A fifth push is held off and does not enter. Then set ready_out = 1 → the four entries emerge in push order, one per cycle, with matching PCs. Afterward count = 0 and valid_out = 0.
- Streaming/wrap: valid_in and ready_out both held at 1 for 12 cycles, with PC incrementing by 4 → after the first-cycle fill, count stays at 1 and outputs follow inputs one cycle later. Pointers wrap at least twice with no PC gap or duplicate.
- Simultaneous push and pop at full: fill to 4, then assert push and pop in the same cycle → pop occurs and push is refused because ready_in = 0. Next cycle count = 3 and ready_in = 1.
- Flush mid-stream: with count = 3, assert flush together with valid_in = 1 and ready_out = 1 → during that cycle ready_in = 0 and valid_out = 0, with no push or pop. Next cycle count = 0. A push of PC 0x100 then appears at the head one cycle later.
- Reset during operation: with count = 2 and a push pending, assert reset → next cycle count = 0, valid_out = 0, instr = pc_out = 0, and no stale entry reappears after reset releases.
